// File: rtl/mvb_rx_ctrl.sv
// MVB receive-frame sequencer: times Manchester half-bit sampling after a start pulse,
// classifies the start delimiter, streams data bits and terminates on end delimiter or error.
module mvb_rx_ctrl #(
  parameter logic [15:0] MSTR_DELIM = 16'hC33C,
  parameter logic [15:0] SLV_DELIM  = 16'h3CC3,
  parameter int          IDLE_CYC   = 16
) (
  input  logic       clk_24M,
  input  logic       rst,
  input  logic       data_in,
  input  logic       frame_start,
  input  logic       rx_en,
  output logic       frame_active,
  output logic       frame_type,
  output logic       bit_data,
  output logic       bit_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [8:0] frame_len
);
  localparam int         IW        = $clog2(IDLE_CYC + 1);
  // Loaded at acceptance so the counter reads F_PT eleven edges later.
  localparam logic [3:0] CELL_LOAD = 4'd10;
  localparam logic [3:0] F_PT      = 4'd4;
  localparam logic [3:0] S_PT      = 4'd12;
  localparam logic [8:0] MAX_BITS  = 9'd288;
  localparam logic [8:0] SLV_LEN [5] = '{9'd24, 9'd40, 9'd72, 9'd144, 9'd288};

  typedef enum logic [1:0] {IDLE, DELIM, DATA, RECOVER} state_t;

  state_t        state_reg;
  logic [3:0]    cell_cnt_reg;
  logic [2:0]    delim_cell_reg;
  logic [14:0]   shift_reg;
  logic          f_reg;
  logic          armed_reg;
  logic [8:0]    bit_cnt_reg;
  logic [IW-1:0] idle_cnt_reg;
  logic          active_reg, type_reg, bit_data_reg, bit_valid_reg, done_reg, err_reg;
  logic [1:0]    code_reg;
  logic [8:0]    len_reg;

  logic [15:0]   delim_word;
  logic [4:0]    len_hit;
  logic          len_ok;

  assign delim_word = {shift_reg, data_in};

  for (genvar gi = 0; gi < 5; gi++) begin : g_len
    assign len_hit[gi] = (bit_cnt_reg == SLV_LEN[gi]);
  end
  assign len_ok = type_reg ? (|len_hit) : len_hit[0];

  always_ff @(posedge clk_24M) begin
    if (rst) begin
      state_reg      <= IDLE;
      cell_cnt_reg   <= '0;
      delim_cell_reg <= '0;
      shift_reg      <= '0;
      f_reg          <= 1'b0;
      armed_reg      <= 1'b0;
      bit_cnt_reg    <= '0;
      idle_cnt_reg   <= '0;
      active_reg     <= 1'b0;
      type_reg       <= 1'b0;
      bit_data_reg   <= 1'b0;
      bit_valid_reg  <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      code_reg       <= 2'b00;
      len_reg        <= '0;
    end else begin
      bit_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      cell_cnt_reg  <= cell_cnt_reg + 4'd1;
      case (state_reg)
        IDLE: begin
          if (frame_start && rx_en) begin
            state_reg      <= DELIM;
            active_reg     <= 1'b1;
            bit_cnt_reg    <= '0;
            cell_cnt_reg   <= CELL_LOAD;
            delim_cell_reg <= '0;
            armed_reg      <= 1'b0;
          end
        end
        DELIM: begin
          if (!rx_en) begin
            state_reg    <= RECOVER;
            active_reg   <= 1'b0;
            idle_cnt_reg <= '0;
          end else if (cell_cnt_reg == F_PT) begin
            shift_reg <= delim_word[14:0];
            armed_reg <= 1'b1;
          end else if (cell_cnt_reg == S_PT && armed_reg) begin
            // The counter also passes S_PT once before the first cell; armed_reg masks it.
            shift_reg      <= delim_word[14:0];
            delim_cell_reg <= delim_cell_reg + 3'd1;
            if (delim_cell_reg == 3'd7) begin
              if (delim_word == MSTR_DELIM) begin
                type_reg  <= 1'b0;
                state_reg <= DATA;
              end else if (delim_word == SLV_DELIM) begin
                type_reg  <= 1'b1;
                state_reg <= DATA;
              end else begin
                err_reg      <= 1'b1;
                code_reg     <= 2'b01;
                len_reg      <= bit_cnt_reg;
                active_reg   <= 1'b0;
                state_reg    <= RECOVER;
                idle_cnt_reg <= '0;
              end
            end
          end
        end
        DATA: begin
          if (!rx_en) begin
            state_reg    <= RECOVER;
            active_reg   <= 1'b0;
            idle_cnt_reg <= '0;
          end else if (cell_cnt_reg == F_PT) begin
            f_reg <= data_in;
          end else if (cell_cnt_reg == S_PT) begin
            if (f_reg != data_in && bit_cnt_reg != MAX_BITS) begin
              bit_data_reg  <= f_reg;
              bit_valid_reg <= 1'b1;
              bit_cnt_reg   <= bit_cnt_reg + 9'd1;
            end else begin
              len_reg      <= bit_cnt_reg;
              active_reg   <= 1'b0;
              state_reg    <= RECOVER;
              idle_cnt_reg <= '0;
              if (f_reg != data_in) begin
                err_reg  <= 1'b1;
                code_reg <= 2'b11;
              end else if (!f_reg && len_ok) begin
                done_reg <= 1'b1;
              end else begin
                err_reg  <= 1'b1;
                code_reg <= 2'b10;
              end
            end
          end
        end
        RECOVER: begin
          if (!data_in) begin
            idle_cnt_reg <= '0;
          end else if (idle_cnt_reg == IW'(IDLE_CYC - 1)) begin
            state_reg <= IDLE;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + IW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign frame_active = active_reg;
  assign frame_type   = type_reg;
  assign bit_data     = bit_data_reg;
  assign bit_valid    = bit_valid_reg;
  assign frame_done   = done_reg;
  assign frame_err    = err_reg;
  assign err_code     = code_reg;
  assign frame_len    = len_reg;
endmodule

// File: tb/tb_mvb_rx_ctrl.sv
// Directed bench for mvb_rx_ctrl: builds half-bit line patterns, scoreboards expected
// bits and frame-end events, and checks them as the DUT produces them.
module tb_mvb_rx_ctrl;
  localparam logic [15:0] MSTR = 16'hC33C;
  localparam logic [15:0] SLV  = 16'h3CC3;

  logic       clk_24M;
  logic       rst, data_in, frame_start, rx_en;
  logic       frame_active, frame_type, bit_data, bit_valid, frame_done, frame_err;
  logic [1:0] err_code;
  logic [8:0] frame_len;

  mvb_rx_ctrl #(.MSTR_DELIM(MSTR), .SLV_DELIM(SLV), .IDLE_CYC(16)) dut (
    .clk_24M(clk_24M), .rst(rst), .data_in(data_in), .frame_start(frame_start),
    .rx_en(rx_en), .frame_active(frame_active), .frame_type(frame_type),
    .bit_data(bit_data), .bit_valid(bit_valid), .frame_done(frame_done),
    .frame_err(frame_err), .err_code(err_code), .frame_len(frame_len)
  );

  initial clk_24M = 1'b0;
  always #21 clk_24M = ~clk_24M;

  logic       halves[$];
  logic       exp_b[$];
  int         exp_rel[$];
  int         rel;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       end_exp, end_is_done, end_type;
  logic [1:0] end_code;
  int         end_rel, end_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (rel %0d)", tag, obs, exp, rel);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_active"}, frame_active, 0);
    chk({tag, "_type"},   frame_type, 0);
    chk({tag, "_bdata"},  bit_data, 0);
    chk({tag, "_bvalid"}, bit_valid, 0);
    chk({tag, "_done"},   frame_done, 0);
    chk({tag, "_err"},    frame_err, 0);
    chk({tag, "_code"},   err_code, 0);
    chk({tag, "_len"},    frame_len, 0);
  endtask

  function automatic logic line_at(input int e);
    int j;
    if (e < 7) return 1'b0;
    j = (e - 7) / 8;
    if (j < halves.size()) return halves[j];
    return 1'b1;
  endfunction

  task automatic monitor();
    if (bit_valid) begin
      if (exp_b.size() == 0) chk("unexp_bit", bit_valid, 0);
      else begin
        chk("bit_data", bit_data, exp_b.pop_front());
        chk("bit_time", rel, exp_rel.pop_front());
        $display("rel %0d: bit %0d", rel, bit_data);
      end
    end
    if (frame_done || frame_err) begin
      if (!end_exp) chk("unexp_end", {frame_done, frame_err}, 0);
      else begin
        chk("end_kind", {frame_done, frame_err}, end_is_done ? 2'b10 : 2'b01);
        chk("end_time", rel, end_rel);
        chk("frame_len", frame_len, end_len);
        chk("frame_type", frame_type, end_type);
        chk("end_active", frame_active, 0);
        if (!end_is_done) chk("err_code", err_code, end_code);
        $display("rel %0d: end done=%0d err=%0d code=%0d len=%0d", rel, frame_done,
                 frame_err, err_code, frame_len);
        end_exp = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk_24M);
    rel++;
    monitor();
    data_in = line_at(rel + 1);
  endtask

  task automatic run_until(input int r);
    while (rel < r) cyc();
  endtask

  task automatic clear_frame();
    halves.delete();
    exp_b.delete();
    exp_rel.delete();
    end_exp = 1'b0;
  endtask

  task automatic add_delim(input logic [15:0] p);
    for (int i = 15; i >= 0; i--) halves.push_back(p[i]);
  endtask

  task automatic add_bit(input logic b, input bit push);
    int n;
    n = (halves.size() - 16) / 2;
    halves.push_back(b);
    halves.push_back(~b);
    if (push) begin
      exp_b.push_back(b);
      exp_rel.push_back(147 + 16 * n);
    end
  endtask

  task automatic add_cell(input logic f, input logic s);
    halves.push_back(f);
    halves.push_back(s);
  endtask

  task automatic expect_end(input bit done, input logic [1:0] code, input int len,
                            input logic typ, input int r);
    end_exp = 1'b1; end_is_done = done; end_code = code;
    end_len = len; end_type = typ; end_rel = r;
  endtask

  // Line low for the start bit; frame_start is sampled at edge T (rel 0).
  task automatic start_frame(input bit with_rst);
    data_in = 1'b0; frame_start = 1'b0; rst = with_rst;
    @(negedge clk_24M);
    if (with_rst) chk_zero("rst_mid");
    rst = 1'b0; frame_start = 1'b1;
    @(negedge clk_24M);
    frame_start = 1'b0; rel = 0;
    chk("accept_active", frame_active, 1);
    data_in = line_at(1);
  endtask

  task automatic finish_frame();
    chk("bits_pending", exp_b.size(), 0);
    chk("end_pending", end_exp, 0);
  endtask

  initial begin
    rst = 1'b1; data_in = 1'b1; frame_start = 1'b0; rx_en = 1'b1; rel = 0;
    clear_frame();
    repeat (3) @(negedge clk_24M);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk_24M);

    // Master frame, 24 alternating bits
    clear_frame(); add_delim(MSTR);
    for (int i = 0; i < 24; i++) add_bit((i % 2) == 0, 1);
    add_cell(0, 0);
    expect_end(1, 2'b00, 24, 0, 147 + 16 * 24);
    start_frame(0); run_until(600); finish_frame();

    // Slave frame, 72 random bits; frame_type switches at T+131
    clear_frame(); add_delim(SLV);
    for (int i = 0; i < 72; i++) add_bit(1'($urandom_range(0, 1)), 1);
    add_cell(0, 0);
    expect_end(1, 2'b00, 72, 1, 147 + 16 * 72);
    start_frame(0);
    run_until(130); chk("type_before", frame_type, 0);
    run_until(131); chk("type_after", frame_type, 1);
    chk("mid_active", frame_active, 1);
    run_until(1350); finish_frame();

    // Bad delimiter, then re-arm timing in RECOVER
    clear_frame(); add_delim(16'hAAAA);
    expect_end(0, 2'b01, 0, 1, 131);
    start_frame(0);
    run_until(139); frame_start = 1'b1; cyc(); frame_start = 1'b0;
    chk("ign_recover", frame_active, 0);
    run_until(149); frame_start = 1'b1; cyc(); frame_start = 1'b0;
    chk("ign_transition", frame_active, 0);
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    chk("rearm", frame_active, 1);
    rx_en = 1'b0; cyc();
    chk("rearm_abort", frame_active, 0);
    run_until(180); rx_en = 1'b1; finish_frame();

    // Master frame with NH at data cell 5
    clear_frame(); add_delim(MSTR);
    for (int i = 0; i < 5; i++) add_bit((i % 2) == 0, 1);
    add_cell(1, 1);
    for (int i = 0; i < 5; i++) add_bit(1'b1, 0);
    add_cell(0, 0);
    expect_end(0, 2'b10, 5, 0, 147 + 16 * 5);
    start_frame(0); run_until(380); finish_frame();

    // Slave NL after 30 bits
    clear_frame(); add_delim(SLV);
    for (int i = 0; i < 30; i++) add_bit(1'($urandom_range(0, 1)), 1);
    add_cell(0, 0);
    expect_end(0, 2'b10, 30, 1, 147 + 16 * 30);
    start_frame(0); run_until(680); finish_frame();

    // Overflow: 289 valid cells
    clear_frame(); add_delim(SLV);
    for (int i = 0; i < 289; i++) add_bit(1'($urandom_range(0, 1)), i < 288);
    expect_end(0, 2'b11, 288, 1, 147 + 16 * 288);
    start_frame(0); run_until(4800); finish_frame();

    // rx_en dropped at data cell 3
    clear_frame(); add_delim(MSTR);
    for (int i = 0; i < 24; i++) add_bit((i % 2) == 0, i < 3);
    add_cell(0, 0);
    start_frame(0);
    run_until(184); chk("pre_abort_active", frame_active, 1);
    rx_en = 1'b0; cyc();
    chk("abort_active", frame_active, 0);
    run_until(600); rx_en = 1'b1; finish_frame();

    // rst mid-DATA, then an immediate new frame
    clear_frame(); add_delim(MSTR);
    for (int i = 0; i < 24; i++) add_bit((i % 2) == 0, i < 4);
    add_cell(0, 0);
    start_frame(0); run_until(199); finish_frame();
    clear_frame(); add_delim(MSTR);
    for (int i = 0; i < 24; i++) add_bit((i % 2) == 1, 1);
    add_cell(0, 0);
    expect_end(1, 2'b00, 24, 0, 147 + 16 * 24);
    start_frame(1); run_until(600); finish_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mvb_rx_ctrl.md
# mvb_rx_ctrl

Receive-frame sequencer for the MVB line interface at 24 MHz (16 clocks per 1.5 Mbit/s bit cell). It arms on the single-cycle frame-start pulse from the start-bit detector, then times Manchester half-bit sampling of the raw line. It classifies the start delimiter as master or slave, and streams decoded data bits. It terminates the frame on a legal end delimiter or on an error, then holds off re-arming until the line has returned to idle.

## Interface
Parameters:
- MSTR_DELIM, 16'hC33C, master start-delimiter half-bit pattern (bit 15 = first half-sample received).
- SLV_DELIM, 16'h3CC3, slave start-delimiter half-bit pattern.
- IDLE_CYC, 16, consecutive high line samples required to leave RECOVER.

Ports:
- clk_24M  in  1  24 MHz clock.
- rst  in  1  synchronous, active-high reset.
- data_in  in  1  raw line. It is the same signal fed to the start detector and is already synchronous to clk_24M.
- frame_start  in  1  one-cycle pulse from the start detector, asserted the cycle after the first low sample.
- rx_en  in  1  receive enable.
- frame_active  out  1  high from frame_start acceptance until frame_done/frame_err.
- frame_type  out  1  0 = master, 1 = slave. Valid from delimiter match; held until the next match.
- bit_data  out  1  decoded data bit.
- bit_valid  out  1  one-cycle strobe qualifying bit_data.
- frame_done  out  1  one-cycle pulse on legal end of frame.
- frame_err  out  1  one-cycle pulse on error.
- err_code  out  2  01 delimiter mismatch, 10 Manchester/length violation, 11 overflow. Held until the next frame_err.
- frame_len  out  9  data-bit count of the last completed or errored frame. Held.

## Operation
- States: IDLE, DELIM, DATA, RECOVER.
- All outputs reset to 0. Reset enters IDLE.
- IDLE: frame_start with rx_en=1 -> DELIM, frame_active=1, and the bit counter is cleared. frame_start in any other state, or with rx_en=0, is ignored.
- Cell timing: a 4-bit cell counter is aligned so each cell begins 8 clocks after the start-bit mid-edge.
  - First half-sample f is taken at cell count 4.
  - Second half-sample s is taken at cell count 12.
- DELIM: 8 cells are sampled, giving 16 half-samples shifted in MSB first.
  - A match with MSTR_DELIM gives frame_type=0 and a transition to DATA.
  - A match with SLV_DELIM gives frame_type=1 and a transition to DATA.
  - Otherwise frame_err with err_code=01, then RECOVER.
- DATA, per cell:
  - If f≠s: bit_data=f, bit_valid pulse, and the bit counter increments.
  - If f=s=0 (end delimiter): the count is legal if it equals 24 for a master frame, or one of 24, 40, 72, 144, 288 for a slave frame.
    - Legal count: frame_done, then RECOVER.
    - Illegal count: frame_err with code 10, then RECOVER.
  - If f=s=1: frame_err with code 10, then RECOVER.
  - If the counter is at 288 and the next cell is a valid data cell: frame_err with code 11, and that bit is not emitted.
- frame_len is loaded with the bit count on every frame_done or frame_err. frame_active drops on that same cycle.
- RECOVER: count consecutive data_in=1 samples and reset the count on any low. When the count reaches IDLE_CYC, go to IDLE.
- rx_en falling in DELIM or DATA aborts the frame. There is no pulse, frame_active drops the next cycle, and the state goes to RECOVER.
- rst in any state returns everything to reset values on the next edge.

## Timing
- Let T be the edge at which frame_start=1 is sampled.
- Delimiter cell k (0..7): samples taken at edges T+11+16k and T+19+16k.
  - The delimiter decision is registered at T+131, and frame_type is visible at T+132.
- Data cell n: samples taken at edges T+139+16n and T+147+16n.
  - bit_valid/bit_data are visible in cycle T+148+16n.
  - frame_done/frame_err for an end delimiter or violation in cell n use the same timing.
- Delimiter errors are visible in cycle T+132.
- Minimum re-arm: the cycle after RECOVER sees IDLE_CYC consecutive highs.
- A frame_start coincident with the RECOVER→IDLE transition is ignored.

## Test plan
- Master frame:
  - Stimulus: start bit, then MSTR_DELIM, then 24 Manchester bits alternating 1,0, then an NL cell.
  - Response: 24 bit_valid strobes with data 1,0,…, frame_type=0, frame_done at T+148+16·24, frame_len=24.
- Slave frame of 72 bits:
  - Stimulus: SLV_DELIM then 72 bits then NL.
  - Response: frame_type=1, frame_done, frame_len=72, no frame_err.
- Bad delimiter:
  - Stimulus: half-bit pattern 16'hAAAA.
  - Response: frame_err with err_code=01 at T+132, no bit_valid, and frame_start is ignored until 16 idle highs have been seen.
- Violations:
  - Stimulus: master frame with an NH cell (f=s=1) at data cell 5.
  - Response: 5 bit_valid strobes, then frame_err with code 10 and frame_len=5.
  - Stimulus: slave NL after 30 bits.
  - Response: code 10, frame_len=30.
- Overflow:
  - Stimulus: slave frame with 289 valid data cells.
  - Response: 288 strobes, frame_err with code 11, frame_len=288.
- Control:
  - Stimulus: rx_en dropped at data cell 3.
  - Response: no done/err pulse, and frame_active falls the next cycle.
  - Stimulus: rst asserted mid-DATA.
  - Response: all outputs are 0 on the next edge, and a new frame_start is accepted immediately.
